// File: rtl/bist_controller.sv
// BIST run sequencer: clears the LFSR/MISR datapath, enables it for NUM_PATTERNS cycles,
// then captures and grades the signature. Define BIST_RUNTIME_GOLDEN_EN for a runtime golden_sig input.
module bist_controller #(
    parameter int               PAT_W        = 8,
    parameter int               SIG_W        = 4,
    parameter int               NUM_PATTERNS = 20,
    parameter logic [SIG_W-1:0] GOLDEN_SIG   = 4'hA,
    localparam int              CNT_W        = $clog2(NUM_PATTERNS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
`ifdef BIST_RUNTIME_GOLDEN_EN
    input  logic [SIG_W-1:0] golden_sig,
`endif
    input  logic [SIG_W-1:0] misr_sig,
    output logic             bist_clear,
    output logic             bist_enable,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [SIG_W-1:0] sig_captured,
    output logic [CNT_W-1:0] pattern_count
);

    if (NUM_PATTERNS < 1) begin : g_bad_num_patterns
        $error("bist_controller: NUM_PATTERNS must be >= 1");
    end
    if (PAT_W < 1) begin : g_bad_pat_w
        $error("bist_controller: PAT_W must be >= 1");
    end

    localparam logic [CNT_W-1:0] LP_NUM = CNT_W'(NUM_PATTERNS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_clear;
    logic               r_enable;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic               r_fail;
    logic [SIG_W-1:0]   r_sig;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_clear_nxt;
    logic               w_enable_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_pass_nxt;
    logic               w_fail_nxt;
    logic [SIG_W-1:0]   w_sig_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    logic [CNT_W-1:0]   w_cnt_inc;
    logic [SIG_W-1:0]   w_golden;
    logic               w_match;

`ifdef BIST_RUNTIME_GOLDEN_EN
    logic               w_load_golden;
    logic [SIG_W-1:0]   r_golden;

    // Golden value is frozen at run launch so it may change freely while the run is in flight.
    assign w_load_golden = !abort && start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_golden <= '0;
        end else if (w_load_golden) begin
            r_golden <= golden_sig;
        end
    end

    assign w_golden = r_golden;
`else
    assign w_golden = GOLDEN_SIG;
`endif

    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_match   = (misr_sig == w_golden);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_clear  <= 1'b0;
            r_enable <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_fail   <= 1'b0;
            r_sig    <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_clear  <= w_clear_nxt;
            r_enable <= w_enable_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_pass   <= w_pass_nxt;
            r_fail   <= w_fail_nxt;
            r_sig    <= w_sig_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    // Outputs are computed one state ahead so every port comes straight from a flop.
    always_comb begin
        w_state_nxt  = r_state;
        w_clear_nxt  = 1'b0;
        w_enable_nxt = 1'b0;
        w_busy_nxt   = r_busy;
        w_done_nxt   = r_done;
        w_pass_nxt   = r_pass;
        w_fail_nxt   = r_fail;
        w_sig_nxt    = r_sig;
        w_cnt_nxt    = r_cnt;

        if (abort) begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
            w_pass_nxt  = 1'b0;
            w_fail_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_state_nxt = S_CLEAR;
                        w_clear_nxt = 1'b1;
                        w_busy_nxt  = 1'b1;
                        w_done_nxt  = 1'b0;
                        w_pass_nxt  = 1'b0;
                        w_fail_nxt  = 1'b0;
                        w_cnt_nxt   = '0;
                    end
                end
                S_CLEAR: begin
                    w_state_nxt  = S_RUN;
                    w_enable_nxt = 1'b1;
                    w_busy_nxt   = 1'b1;
                end
                S_RUN: begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == LP_NUM) begin
                        w_state_nxt = S_CAPTURE;
                    end else begin
                        w_enable_nxt = 1'b1;
                    end
                end
                S_CAPTURE: begin
                    w_state_nxt = S_DONE;
                    w_sig_nxt   = misr_sig;
                    w_pass_nxt  = w_match;
                    w_fail_nxt  = !w_match;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b0;
                    w_pass_nxt  = 1'b0;
                    w_fail_nxt  = 1'b0;
                end
            endcase
        end
    end

    assign bist_clear    = r_clear;
    assign bist_enable   = r_enable;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign fail          = r_fail;
    assign sig_captured  = r_sig;
    assign pattern_count = r_cnt;

endmodule

// File: tb/tb_bist_controller.sv
// Self-checking bench for bist_controller: directed scenarios plus random start/abort/signature
// traffic, graded every cycle against a run-timeline reference model.
module tb_bist_controller;

    localparam int N  = 20;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [3:0]    misr_sig = 4'h0;
`ifdef BIST_RUNTIME_GOLDEN_EN
    logic [3:0]    golden_sig = 4'h0;
    logic [3:0]    smp_gold;
`endif
    logic          bist_clear, bist_enable, busy, done, pass, fail;
    logic [3:0]    sig_captured;
    logic [CW-1:0] pattern_count;

    always #5 clk = ~clk;

    bist_controller #(
        .PAT_W        (8),
        .SIG_W        (4),
        .NUM_PATTERNS (N),
        .GOLDEN_SIG   (4'hA)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
`ifdef BIST_RUNTIME_GOLDEN_EN
        .golden_sig    (golden_sig),
`endif
        .misr_sig      (misr_sig),
        .bist_clear    (bist_clear),
        .bist_enable   (bist_enable),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .fail          (fail),
        .sig_captured  (sig_captured),
        .pattern_count (pattern_count)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: m_t counts edges since the launching edge of the current run.
    int         m_mode;   // 0 idle, 1 running, 2 done
    int         m_t;
    logic [3:0] m_golden;
    logic       e_clear, e_enable, e_busy, e_done, e_pass, e_fail;
    logic [3:0] e_sig;
    int         e_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        check({ph, ".bist_clear"},    32'(bist_clear),    32'(e_clear));
        check({ph, ".bist_enable"},   32'(bist_enable),   32'(e_enable));
        check({ph, ".busy"},          32'(busy),          32'(e_busy));
        check({ph, ".done"},          32'(done),          32'(e_done));
        check({ph, ".pass"},          32'(pass),          32'(e_pass));
        check({ph, ".fail"},          32'(fail),          32'(e_fail));
        check({ph, ".sig_captured"},  32'(sig_captured),  32'(e_sig));
        check({ph, ".pattern_count"}, 32'(pattern_count), 32'(e_cnt));
    endtask

    task automatic model_reset();
        m_mode = 0; m_t = 0; m_golden = 4'h0;
        e_clear = 0; e_enable = 0; e_busy = 0; e_done = 0; e_pass = 0; e_fail = 0;
        e_sig = 4'h0; e_cnt = 0;
    endtask

    task automatic model_edge(input logic s_start, input logic s_abort, input logic [3:0] s_misr);
        if (s_abort) begin
            m_mode = 0;
            e_clear = 0; e_enable = 0; e_busy = 0; e_done = 0; e_pass = 0; e_fail = 0;
        end else begin
            if (m_mode != 1 && s_start) begin
                m_mode = 1; m_t = 0;
                e_done = 0; e_pass = 0; e_fail = 0;
`ifdef BIST_RUNTIME_GOLDEN_EN
                m_golden = smp_gold;
`else
                m_golden = 4'hA;
`endif
            end else if (m_mode == 1) begin
                m_t++;
            end
            if (m_mode == 1) begin
                e_clear  = (m_t == 0);
                e_enable = (m_t >= 1 && m_t <= N);
                e_busy   = (m_t <= N + 1);
                e_cnt    = (m_t <= 1) ? 0 : ((m_t - 1 > N) ? N : m_t - 1);
                if (m_t == N + 2) begin
                    e_sig  = s_misr;
                    e_pass = (s_misr == m_golden);
                    e_fail = !e_pass;
                    e_done = 1;
                    m_mode = 2;
                end
            end
        end
    endtask

    task automatic tick(input string ph);
        logic       s_start, s_abort;
        logic [3:0] s_misr;
        s_start = start; s_abort = abort; s_misr = misr_sig;
`ifdef BIST_RUNTIME_GOLDEN_EN
        smp_gold = golden_sig;
`endif
        @(posedge clk);
        model_edge(s_start, s_abort, s_misr);
        #1;
        check_all(ph);
    endtask

    // Launches one run and observes it until done, bounded by a cycle budget.
    task automatic run_measure(input string ph, output int lat, output int en, output int clr);
        lat = 0; en = 0; clr = 0;
        start = 1'b1;
        tick(ph);
        start = 1'b0;
        if (bist_clear) clr++;
        while (!done && lat < 40) begin
            tick(ph);
            lat++;
            if (bist_clear)  clr++;
            if (bist_enable) en++;
        end
    endtask

    initial begin
        int lat, en, clr, guard;

        model_reset();
        misr_sig = 4'hA;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b1;
        tick("idle0");
        tick("idle1");

        // 1: matching signature
        run_measure("t1", lat, en, clr);
        check("t1.latency", 32'(lat), 32'd22);
        check("t1.enable_cycles", 32'(en), 32'(N));
        check("t1.clear_cycles", 32'(clr), 32'd1);
        check("t1.pass", 32'(pass), 32'd1);
        check("t1.fail", 32'(fail), 32'd0);
        check("t1.sig", 32'(sig_captured), 32'hA);
        check("t1.count", 32'(pattern_count), 32'(N));
        tick("t1.hold");
        tick("t1.hold");

        // 2: mismatching signature
        misr_sig = 4'h3;
        run_measure("t2", lat, en, clr);
        check("t2.done", 32'(done), 32'd1);
        check("t2.pass", 32'(pass), 32'd0);
        check("t2.fail", 32'(fail), 32'd1);
        check("t2.sig", 32'(sig_captured), 32'h3);

        // 3: abort once ten enable cycles have been counted
        misr_sig = 4'($urandom_range(0, 15));
        start = 1'b1;
        tick("t3.start");
        start = 1'b0;
        guard = 0;
        while (pattern_count != CW'(10) && guard < 30) begin
            tick("t3.run");
            guard++;
        end
        check("t3.reached10", 32'(pattern_count), 32'd10);
        abort = 1'b1;
        start = 1'b1;
        tick("t3.abort");
        abort = 1'b0;
        start = 1'b0;
        check("t3.count_hold", 32'(pattern_count), 32'd10);
        check("t3.busy", 32'(busy), 32'd0);
        check("t3.enable", 32'(bist_enable), 32'd0);
        check("t3.done", 32'(done), 32'd0);
        repeat (3) tick("t3.idle");
        misr_sig = 4'hA;
        run_measure("t3.rerun", lat, en, clr);
        check("t3.rerun_enables", 32'(en), 32'(N));
        check("t3.rerun_pass", 32'(pass), 32'd1);

        // 4: asynchronous reset mid-run
        start = 1'b1;
        tick("t4.start");
        start = 1'b0;
        repeat (7) tick("t4.run");
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("t4.async");
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (4) tick("t4.quiet");
        check("t4.quiet_busy", 32'(busy), 32'd0);

        // 5: start held through two back-to-back runs
        misr_sig = 4'hA;
        start = 1'b1;
        for (int r = 0; r < 2; r++) begin
            guard = 0;
            while (!done && guard < 40) begin
                tick("t5.run");
                guard++;
            end
            check("t5.done", 32'(done), 32'd1);
            check("t5.pass", 32'(pass), (r == 0) ? 32'd1 : 32'd0);
            check("t5.fail", 32'(fail), (r == 0) ? 32'd0 : 32'd1);
            misr_sig = 4'h5;
            tick("t5.restart");
            check("t5.done_one_cycle", 32'(done), 32'd0);
            check("t5.clear_pulse", 32'(bist_clear), 32'd1);
        end
        start = 1'b0;
        abort = 1'b1;
        tick("t5.abort");
        abort = 1'b0;

        // 6: golden source
`ifdef BIST_RUNTIME_GOLDEN_EN
        golden_sig = 4'h5;
        misr_sig = 4'h5;
        start = 1'b1;
        tick("t6.start");
        start = 1'b0;
        repeat (5) tick("t6.run");
        golden_sig = 4'h0;
        guard = 0;
        while (!done && guard < 40) begin
            tick("t6.run");
            guard++;
        end
        check("t6.pass_latched_golden", 32'(pass), 32'd1);
`else
        misr_sig = 4'h5;
        run_measure("t6", lat, en, clr);
        check("t6.param_golden_fail", 32'(fail), 32'd1);
`endif

        // 7: random start/abort/signature traffic
        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 9) < 3);
            abort = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 7) == 0)
                misr_sig = ($urandom_range(0, 1) == 0) ? 4'hA : 4'($urandom_range(0, 15));
`ifdef BIST_RUNTIME_GOLDEN_EN
            if ($urandom_range(0, 15) == 0)
                golden_sig = ($urandom_range(0, 1) == 0) ? misr_sig : 4'($urandom_range(0, 15));
`endif
            tick("t7.rand");
            check("t7.pass_fail_excl", 32'(pass & fail), 32'd0);
        end
        start = 1'b0;
        abort = 1'b0;
        tick("end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
